// File: rtl/number_match_game.sv
// Number-matching game back end: accumulates 4-bit entries toward TARGET once
// access control unlocks play; win on exact hit, lose on overshoot or no tries left.
module number_match_game #(
    parameter logic [7:0] TARGET    = 8'd50,
    parameter logic [3:0] MAX_TRIES = 4'd8
) (
    input  logic       Clk,
    input  logic       rts,
    input  logic       adderEnable,
    input  logic       adderDisable,
    input  logic       enter,
    input  logic [3:0] number,
    output logic [7:0] sum,
    output logic [3:0] triesLeft,
    output logic       playing,
    output logic       win,
    output logic       lose,
    output logic [2:0] o_dbg_state
);

    localparam logic [2:0] S_LOCKED = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WIN    = 3'd3;
    localparam logic [2:0] S_LOSE   = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_sum;
    logic [3:0] r_tries;
    logic [8:0] w_sum_wide;
    logic [7:0] w_sum_sat;

    // Nine-bit add so a carry out of the running sum clamps to 255 instead of wrapping.
    assign w_sum_wide = {1'b0, r_sum} + {5'b0_0000, number};
    assign w_sum_sat  = w_sum_wide[8] ? 8'hFF : w_sum_wide[7:0];

    always_ff @(posedge Clk or negedge rts) begin
        if (!rts) begin
            r_state <= S_LOCKED;
            r_sum   <= 8'd0;
            r_tries <= MAX_TRIES;
        end else if (adderDisable) begin
            r_state <= S_LOCKED;
            r_sum   <= 8'd0;
            r_tries <= MAX_TRIES;
        end else begin
            case (r_state)
                S_LOCKED: begin
                    if (adderEnable) begin
                        r_state <= S_PLAY;
                        r_sum   <= 8'd0;
                        r_tries <= MAX_TRIES;
                    end
                end
                S_PLAY: begin
                    if (enter) begin
                        r_sum   <= w_sum_sat;
                        r_tries <= r_tries - 4'd1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_sum == TARGET)      r_state <= S_WIN;
                    else if (r_sum > TARGET)  r_state <= S_LOSE;
                    else if (r_tries == 4'd0) r_state <= S_LOSE;
                    else                      r_state <= S_PLAY;
                end
                S_WIN, S_LOSE: begin
                    // The restart pulse only clears; its number is not added.
                    if (enter) begin
                        r_state <= S_PLAY;
                        r_sum   <= 8'd0;
                        r_tries <= MAX_TRIES;
                    end
                end
                default: begin
                    r_state <= S_LOCKED;
                    r_sum   <= 8'd0;
                    r_tries <= MAX_TRIES;
                end
            endcase
        end
    end

    assign sum         = r_sum;
    assign triesLeft   = r_tries;
    assign playing     = (r_state == S_PLAY) || (r_state == S_CHECK);
    assign win         = (r_state == S_WIN);
    assign lose        = (r_state == S_LOSE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_number_match_game.sv
// Directed bench for number_match_game: locked behaviour, win, overshoot,
// tries exhausted, lock priority, async reset and dropped pulses.
module tb_number_match_game;

    localparam logic [2:0] S_LOCKED = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WIN    = 3'd3;
    localparam logic [2:0] S_LOSE   = 3'd4;

    logic       Clk;
    logic       rts;
    logic       adderEnable;
    logic       adderDisable;
    logic       enter;
    logic [3:0] number;
    logic [7:0] sum;
    logic [3:0] triesLeft;
    logic       playing;
    logic       win;
    logic       lose;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    number_match_game #(.TARGET(8'd50), .MAX_TRIES(4'd8)) dut (
        .Clk          (Clk),
        .rts          (rts),
        .adderEnable  (adderEnable),
        .adderDisable (adderDisable),
        .enter        (enter),
        .number       (number),
        .sum          (sum),
        .triesLeft    (triesLeft),
        .playing      (playing),
        .win          (win),
        .lose         (lose),
        .o_dbg_state  (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [3:0] n);
        enter  = 1'b1;
        number = n;
        tick();
        enter  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, {13'd0, dbg_state}, {13'd0, S_LOCKED});
        chk({tag, "_sum"}, {8'd0, sum}, 16'd0);
        chk({tag, "_tries"}, {12'd0, triesLeft}, 16'd8);
        chk({tag, "_flags"}, {13'd0, playing, win, lose}, 16'd0);
    endtask

    initial begin
        logic [7:0] exp_sum;
        logic [3:0] win_seq [6];
        win_seq = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd5};

        rts = 1'b0; adderEnable = 1'b0; adderDisable = 1'b0;
        enter = 1'b0; number = 4'd0;
        #12;
        chk_idle("reset");
        rts = 1'b1;
        tick();

        // 1. Locked: entries ignored without enable
        for (int i = 0; i < 3; i++) begin
            press(4'd7);
            tick();
        end
        chk_idle("locked");

        // 2. Win path
        adderEnable = 1'b1;
        tick();
        adderEnable = 1'b0;
        chk("unlock_playing", {15'd0, playing}, 16'd1);
        chk("unlock_state", {13'd0, dbg_state}, {13'd0, S_PLAY});
        exp_sum = 8'd0;
        for (int i = 0; i < 6; i++) begin
            press(win_seq[i]);
            exp_sum = exp_sum + {4'd0, win_seq[i]};
            chk("win_sum", {8'd0, sum}, {8'd0, exp_sum});
            chk("win_check_state", {13'd0, dbg_state}, {13'd0, S_CHECK});
            tick();
        end
        chk("win_flag", {13'd0, playing, win, lose}, 16'b010);
        chk("win_tries", {12'd0, triesLeft}, 16'd2);
        tick();
        chk("win_hold", {13'd0, playing, win, lose}, 16'b010);
        chk("win_hold_sum", {8'd0, sum}, 16'd50);
        press(4'd6);
        chk("restart_sum", {8'd0, sum}, 16'd0);
        chk("restart_tries", {12'd0, triesLeft}, 16'd8);
        chk("restart_state", {13'd0, dbg_state}, {13'd0, S_PLAY});

        // 3. Overshoot
        for (int i = 0; i < 3; i++) begin
            press(4'd15);
            tick();
        end
        chk("over_sum45", {8'd0, sum}, 16'd45);
        chk("over_still_playing", {13'd0, playing, win, lose}, 16'b100);
        press(4'd15);
        chk("over_sum60", {8'd0, sum}, 16'd60);
        tick();
        chk("over_lose", {13'd0, playing, win, lose}, 16'b001);
        chk("over_tries", {12'd0, triesLeft}, 16'd4);

        // 4. Tries exhausted
        press(4'd3);
        chk("restart2_sum", {8'd0, sum}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            press(4'd1);
            tick();
            if (i < 7) chk("tries_playing", {15'd0, playing}, 16'd1);
        end
        chk("tries_sum", {8'd0, sum}, 16'd8);
        chk("tries_left", {12'd0, triesLeft}, 16'd0);
        chk("tries_lose", {13'd0, playing, win, lose}, 16'b001);

        // 5. Lock priority
        press(4'd0);
        press(4'd10); tick();
        press(4'd10); tick();
        chk("mid_sum20", {8'd0, sum}, 16'd20);
        adderDisable = 1'b1;
        tick();
        chk_idle("disable_mid");
        adderEnable = 1'b1;
        tick();
        chk_idle("en_and_dis");
        adderDisable = 1'b0;
        tick();
        adderEnable = 1'b0;
        chk("reenable_state", {13'd0, dbg_state}, {13'd0, S_PLAY});
        adderDisable = 1'b1;
        press(4'd9);
        adderDisable = 1'b0;
        chk_idle("enter_with_dis");
        press(4'd4);
        adderDisable = 1'b1;
        tick();
        adderDisable = 1'b0;
        chk_idle("enable_needed_after_lock");

        // Disable landing on the CHECK cycle
        adderEnable = 1'b1; tick(); adderEnable = 1'b0;
        press(4'd12);
        chk("pre_dis_check", {13'd0, dbg_state}, {13'd0, S_CHECK});
        adderDisable = 1'b1;
        tick();
        adderDisable = 1'b0;
        chk_idle("dis_in_check");

        // 6. Dropped pulse during CHECK, then async reset during CHECK
        adderEnable = 1'b1; tick(); adderEnable = 1'b0;
        press(4'd3);
        chk("drop_pre_sum", {8'd0, sum}, 16'd3);
        press(4'd5);
        chk("drop_sum", {8'd0, sum}, 16'd3);
        chk("drop_tries", {12'd0, triesLeft}, 16'd7);
        chk("drop_state", {13'd0, dbg_state}, {13'd0, S_PLAY});
        press(4'd4);
        chk("async_pre_sum", {8'd0, sum}, 16'd7);
        #2;
        rts = 1'b0;
        #1;
        chk_idle("async_reset");
        tick();
        rts = 1'b1;
        tick();
        chk_idle("after_release");
        adderEnable = 1'b1; tick(); adderEnable = 1'b0;
        chk("release_unlock", {13'd0, dbg_state}, {13'd0, S_PLAY});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
